muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Operands come from the forwarded ALU operand muxes (alu_d1, alu_d2). HI/LO feed the EX result path for MFHI/MFLO. busy is consumed by the hazard logic (bubbler) to stall the front end.

Parameters:
WIDTH, 32, operand and HI/LO width.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
start  in  1  request; sampled only when busy=0.
op  in  3  operation code, decoded per the shared package.
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
b  in  WIDTH  rt operand (divisor / multiplier).
busy  out  1  operation in progress.
done  out  1  one-cycle pulse; HI/LO are updated in this cycle.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
div_zero  out  1  sticky flag: last DIV/DIVU had b=0. Cleared by the next start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0. Applies on any edge with reset=0, including mid-operation. In that case the operation is aborted and no partial result is written.
- States:
  - IDLE: start=1 with op=MTHI/MTLO writes a into hi/lo at that edge. done pulses next cycle; state stays IDLE (1-cycle latency).
  - IDLE: start=1 with MULT/MULTU/DIV/DIVU latches |a| and |b| (signed ops) or raw a, b (unsigned ops). It also latches the result sign bits, clears count, and moves to CALC with busy=1.
  - CALC: one iteration per cycle; count runs 0..WIDTH-1. On the edge where count=WIDTH-1, go to FIX.
  - FIX: apply sign correction, write hi/lo, done=1 for one cycle, busy=0, go to IDLE.
- Latency: start sampled at edge E0. busy is high after E0 through E32. hi/lo are written and done=1 after E33 (33 cycles). A new start may be accepted at E34.
- Multiply: shift-add over a 2*WIDTH product register. hi = upper word, lo = lower word. Signed: negate the 64-bit product if the operand signs differ.
- Divide: restoring division, one quotient bit per cycle. lo = quotient, hi = remainder. Signed: quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
- Divide by zero: still takes the full latency. Result is lo=all ones, hi=a (original dividend), div_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF: result wraps to lo=0x80000000, hi=0. No trap.
- start while busy=1: ignored, no queueing. The stall logic must not issue a new op.
- hi/lo hold their old values throughout CALC/FIX until the done edge, so MFHI/MFLO never see partial results.
- Unknown op codes with start=1: ignored, no state change.

Decomposition:
- Shared package holds:
  - op codes: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - state encodings: IDLE, CALC, FIX.
  - WIDTH default constant.
- One natural sub-module: md_signfix. It is combinational: it takes the absolute value of the inputs and negates the outputs, and is shared by the entry and FIX steps.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
2. MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1. Next MTLO a=5 -> lo=5 after 1 cycle, div_zero=0.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
5. MULT a=6, b=7, with a second start (MTHI a=0xDEAD) at cycle 10 -> second start ignored; final hi=0, lo=42.
6. DIVU a=100, b=7 in progress; reset=0 at cycle 15 -> next cycle busy=0, hi=lo=0. After release, DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states and default width.
package muldiv_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_OP_W  = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Multi-cycle ops that go through CALC/FIX
  function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_unit_md_signfix.sv
// Combinational sign handling: operand magnitudes at entry, result negation at FIX.
module md_signfix
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_abs_a,
  output logic [WIDTH-1:0] o_abs_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_mul,
  input  logic             i_neg_hi,
  input  logic             i_neg_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_prod_neg;
  logic [WIDTH-1:0] w_hi_neg;
  logic [WIDTH-1:0] w_lo_neg;

  assign o_abs_a = (i_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
  assign o_abs_b = (i_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

  // Products negate as one double word; quotient/remainder negate independently
  assign w_prod     = {i_hi, i_lo};
  assign w_prod_neg = ~w_prod + PW'(1);
  assign w_hi_neg   = ~i_hi + WIDTH'(1);
  assign w_lo_neg   = ~i_lo + WIDTH'(1);

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_mul) begin
      if (i_neg_hi) begin
        o_hi = w_prod_neg[PW-1:WIDTH];
        o_lo = w_prod_neg[WIDTH-1:0];
      end
    end else begin
      if (i_neg_hi) o_hi = w_hi_neg;
      if (i_neg_lo) o_lo = w_lo_neg;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one bit per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_zero
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        r_state,    r_state_nxt;
  logic             r_busy,     r_busy_nxt;
  logic             r_done,     r_done_nxt;
  logic [WIDTH-1:0] r_hi,       r_hi_nxt;
  logic [WIDTH-1:0] r_lo,       r_lo_nxt;
  logic             r_div_zero, r_div_zero_nxt;
  logic [PW-1:0]    r_p,        r_p_nxt;
  logic [WIDTH-1:0] r_opb,      r_opb_nxt;
  logic [WIDTH-1:0] r_a_orig,   r_a_orig_nxt;
  logic             r_is_mul,   r_is_mul_nxt;
  logic             r_neg_hi,   r_neg_hi_nxt;
  logic             r_neg_lo,   r_neg_lo_nxt;
  logic             r_bzero,    r_bzero_nxt;
  logic [CW-1:0]    r_count,    r_count_nxt;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;
  logic             w_signed;
  logic             w_mul;
  logic [WIDTH:0]   w_mul_add;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ok;
  logic [PW-1:0]    w_mul_step;
  logic [PW-1:0]    w_div_step;

  assign w_signed = md_is_signed(op);
  assign w_mul    = md_is_mul(op);

  md_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_a      (a),
    .i_b      (b),
    .i_signed (w_signed),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .i_hi     (r_p[PW-1:WIDTH]),
    .i_lo     (r_p[WIDTH-1:0]),
    .i_mul    (r_is_mul),
    .i_neg_hi (r_neg_hi),
    .i_neg_lo (r_neg_lo),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // Shift-add: conditionally add multiplicand to upper half, then shift the whole product right
  assign w_mul_add  = r_p[0] ? {1'b0, r_opb} : {(WIDTH + 1){1'b0}};
  assign w_mul_sum  = {1'b0, r_p[PW-1:WIDTH]} + w_mul_add;
  assign w_mul_step = {w_mul_sum, r_p[WIDTH-1:1]};

  // Restoring division: {remainder, dividend/quotient} shifts left, trial-subtract divisor
  assign w_div_sh   = r_p[PW-2:WIDTH-1];
  assign w_div_diff = w_div_sh - {1'b0, r_opb};
  assign w_div_ok   = ~w_div_diff[WIDTH];
  assign w_div_step = w_div_ok ? {w_div_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1}
                               : {r_p[PW-2:0], 1'b0};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
      r_p        <= '0;
      r_opb      <= '0;
      r_a_orig   <= '0;
      r_is_mul   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_bzero    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= r_state_nxt;
      r_busy     <= r_busy_nxt;
      r_done     <= r_done_nxt;
      r_hi       <= r_hi_nxt;
      r_lo       <= r_lo_nxt;
      r_div_zero <= r_div_zero_nxt;
      r_p        <= r_p_nxt;
      r_opb      <= r_opb_nxt;
      r_a_orig   <= r_a_orig_nxt;
      r_is_mul   <= r_is_mul_nxt;
      r_neg_hi   <= r_neg_hi_nxt;
      r_neg_lo   <= r_neg_lo_nxt;
      r_bzero    <= r_bzero_nxt;
      r_count    <= r_count_nxt;
    end
  end

  always_comb begin
    r_state_nxt    = r_state;
    r_busy_nxt     = r_busy;
    r_done_nxt     = 1'b0;
    r_hi_nxt       = r_hi;
    r_lo_nxt       = r_lo;
    r_div_zero_nxt = r_div_zero;
    r_p_nxt        = r_p;
    r_opb_nxt      = r_opb;
    r_a_orig_nxt   = r_a_orig;
    r_is_mul_nxt   = r_is_mul;
    r_neg_hi_nxt   = r_neg_hi;
    r_neg_lo_nxt   = r_neg_lo;
    r_bzero_nxt    = r_bzero;
    r_count_nxt    = r_count;

    case (r_state)
      ST_IDLE: begin
        r_busy_nxt = 1'b0;
        if (start) begin
          if (op == MD_MTHI) begin
            r_hi_nxt       = a;
            r_done_nxt     = 1'b1;
            r_div_zero_nxt = 1'b0;
          end else if (op == MD_MTLO) begin
            r_lo_nxt       = a;
            r_done_nxt     = 1'b1;
            r_div_zero_nxt = 1'b0;
          end else if (md_is_arith(op)) begin
            r_state_nxt    = ST_CALC;
            r_busy_nxt     = 1'b1;
            r_div_zero_nxt = 1'b0;
            r_count_nxt    = '0;
            r_is_mul_nxt   = w_mul;
            r_a_orig_nxt   = a;
            r_bzero_nxt    = (b == '0);
            // Multiplier sits in the low half; dividend shifts out of the low half
            r_opb_nxt      = w_mul ? w_abs_a : w_abs_b;
            r_p_nxt        = {{WIDTH{1'b0}}, (w_mul ? w_abs_b : w_abs_a)};
            if (w_mul) begin
              r_neg_hi_nxt = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_lo_nxt = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            end else begin
              r_neg_hi_nxt = w_signed && a[WIDTH-1];
              r_neg_lo_nxt = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            end
          end
        end
      end

      ST_CALC: begin
        r_p_nxt     = r_is_mul ? w_mul_step : w_div_step;
        r_count_nxt = r_count + CW'(1);
        if (r_count == CW'(WIDTH - 1)) r_state_nxt = ST_FIX;
      end

      ST_FIX: begin
        r_state_nxt = ST_IDLE;
        r_busy_nxt  = 1'b0;
        r_done_nxt  = 1'b1;
        if (!r_is_mul && r_bzero) begin
          r_lo_nxt       = '1;
          r_hi_nxt       = r_a_orig;
          r_div_zero_nxt = 1'b1;
        end else begin
          r_hi_nxt = w_fix_hi;
          r_lo_nxt = w_fix_lo;
        end
      end

      default: begin
        r_state_nxt = ST_IDLE;
        r_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_checks;
  int n_errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dz;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one op, from plain integer arithmetic
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sq, sr;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: begin up = sx * sy; {m_hi, m_lo} = up; m_dz = 1'b0; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = up; m_dz = 1'b0; end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x; m_dz = 1'b1;
        end else if (o == 3'd2) begin
          sq = sx / sy; sr = sx % sy;
          m_lo = sq[31:0]; m_hi = sr[31:0]; m_dz = 1'b0;
        end else begin
          m_lo = x / y; m_hi = x % y; m_dz = 1'b0;
        end
      end
      3'd4: begin m_hi = x; m_dz = 1'b0; end
      3'd5: begin m_lo = x; m_dz = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
  endtask

  // Issue one op; optionally inject a second start inj_at cycles later while busy
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj_at, input logic [2:0] inj_op, input logic [31:0] inj_a);
    int  lat;
    int  bcnt;
    bit  arith;
    arith = (o < 3'd4);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1;
    start = 1'b0;
    model(o, x, y);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == inj_at) begin
        start = 1'b1; op = inj_op; a = inj_a;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    chk($sformatf("done op%0d", o), 64'(done), 64'd1);
    chk($sformatf("hi op%0d %h %h", o, x, y), 64'(hi), 64'(m_hi));
    chk($sformatf("lo op%0d %h %h", o, x, y), 64'(lo), 64'(m_lo));
    chk($sformatf("div_zero op%0d", o), 64'(div_zero), 64'(m_dz));
    chk($sformatf("latency op%0d", o), 64'(lat), arith ? 64'd33 : 64'd0);
    chk($sformatf("busy_cycles op%0d", o), 64'(bcnt), arith ? 64'd33 : 64'd0);
    @(posedge clock);
    #1;
    chk("done_pulse_len", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    do_reset();

    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst div_zero", 64'(div_zero), 64'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    chk("multu max hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu max lo", 64'(lo), 64'h0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, 3'd0, 32'd0);
    chk("mult -3*7 lo", 64'(lo), 64'hFFFF_FFEB);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, 32'd0);
    chk("div -7/2 lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div -7/2 hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(3'd3, 32'h1234, 32'd0, -1, 3'd0, 32'd0);
    chk("divu /0 hi", 64'(hi), 64'h0000_1234);
    chk("divu /0 flag", 64'(div_zero), 64'd1);
    run_op(3'd5, 32'd5, 32'd0, -1, 3'd0, 32'd0);
    chk("mtlo lo", 64'(lo), 64'd5);
    chk("mtlo clears div_zero", 64'(div_zero), 64'd0);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    chk("div ovf lo", 64'(lo), 64'h8000_0000);
    chk("div ovf hi", 64'(hi), 64'd0);

    run_op(3'd0, 32'd6, 32'd7, 10, 3'd4, 32'hDEAD);
    chk("mult busy-start hi", 64'(hi), 64'd0);
    chk("mult busy-start lo", 64'(lo), 64'd42);

    // Abort a divide mid-flight with reset
    run_op(3'd4, 32'h55AA, 32'd0, -1, 3'd0, 32'd0);
    @(negedge clock);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    run_op(3'd3, 32'd100, 32'd7, -1, 3'd0, 32'd0);
    chk("divu 100/7 lo", 64'(lo), 64'd14);
    chk("divu 100/7 hi", 64'(hi), 64'd2);

    for (int i = 0; i < 48; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if (o >= 3'd6) begin
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("unknown op busy", 64'(busy), 64'd0);
        chk("unknown op done", 64'(done), 64'd0);
        chk("unknown op hi", 64'(hi), 64'(m_hi));
        chk("unknown op lo", 64'(lo), 64'(m_lo));
        chk("unknown op div_zero", 64'(div_zero), 64'(m_dz));
      end else begin
        run_op(o, x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : -1,
               3'($urandom_range(0, 5)), $urandom());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
